// File: rtl/bitonic_sort_frame_ctrl.sv
// Frame sequencer for a 32-input pipelined bitonic sorting network.
// Fills a 32-slot input buffer from a valid/ready stream, holds it on the
// network for SORT_LAT+1 cycles, captures the sorted result, and replays it.
// Optional feature macro: SORT_PAD_EN (early end of frame via in_last; the
// unused slots are padded with all-ones so they sort to the top).
module bitonic_sort_frame_ctrl #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SORT_LAT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  output logic [WIDTH-1:0] sort_in [0:31],
  input  logic [WIDTH-1:0] sort_out [0:31],
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned N     = 32;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned LAT_W = (SORT_LAT < 1) ? 1 : $clog2(SORT_LAT + 1);

  typedef enum logic [1:0] {FILL, WAIT, DRAIN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic [LAT_W-1:0]   lat_cnt;
  logic [WIDTH-1:0]   ibuf [0:N-1];
  logic [WIDTH-1:0]   obuf [0:N-1];
  logic [IDX_W-1:0]   last_idx;
  logic               frame_end_c;

`ifdef SORT_PAD_EN
  // Frame ends on slot 31 or on an early in_last.
  assign frame_end_c = in_last || (wr_idx == IDX_W'(N - 1));
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  // Fixed-size frames: only slot 31 ends the frame.
  assign frame_end_c = (wr_idx == IDX_W'(N - 1));
  assign last_idx    = IDX_W'(N - 1);
`endif

  // The network sees the input buffer directly; it only changes during FILL.
  assign sort_in = ibuf;

  // Frame FSM with all handshake outputs registered. DRAIN spends its first
  // cycle loading out_data from obuf, which puts first out_valid SORT_LAT+2
  // cycles after the final accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      wr_idx    <= '0;
      rd_idx    <= '0;
      lat_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      for (int i = 0; i < N; i++) begin
        ibuf[i] <= '0;
        obuf[i] <= '0;
      end
`ifdef SORT_PAD_EN
      last_idx  <= IDX_W'(N - 1);
`endif
    end else begin
      case (state)
        FILL: begin
          if (in_valid && in_ready) begin
            ibuf[wr_idx] <= in_data;
            wr_idx       <= wr_idx + IDX_W'(1);
            if (frame_end_c) begin
`ifdef SORT_PAD_EN
              for (int i = 0; i < N; i++) begin
                if (IDX_W'(i) > wr_idx) ibuf[i] <= '1;
              end
              last_idx <= wr_idx;
`endif
              state    <= WAIT;
              lat_cnt  <= LAT_W'(SORT_LAT);
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            obuf   <= sort_out;
            rd_idx <= '0;
            state  <= DRAIN;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        DRAIN: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= obuf[rd_idx];
            out_last  <= (rd_idx == last_idx);
          end else if (out_ready) begin
            if (rd_idx == last_idx) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              wr_idx    <= '0;
              frame_cnt <= frame_cnt + 16'd1;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= FILL;
            end else begin
              rd_idx   <= rd_idx + IDX_W'(1);
              out_data <= obuf[rd_idx + IDX_W'(1)];
              out_last <= ((rd_idx + IDX_W'(1)) == last_idx);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_bitonic_sort_frame_ctrl.sv
// Self-checking bench for bitonic_sort_frame_ctrl. Provides a behavioural
// sorting network (rank-based, SORT_LAT register stages) and checks the
// replayed stream against a queue-sorted reference of accepted inputs.
module tb_bitonic_sort_frame_ctrl;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned SORT_LAT = 15;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [WIDTH-1:0] sort_in [0:31];
  logic [WIDTH-1:0] sort_out [0:31];
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic [15:0]      frame_cnt;

  bitonic_sort_frame_ctrl #(.WIDTH(WIDTH), .SORT_LAT(SORT_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .sort_in(sort_in), .sort_out(sort_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_frames = 0;
  logic [WIDTH-1:0] sent_q[$];
  logic [WIDTH-1:0] got_q[$];
  logic             last_q[$];

  // Behavioural network: each element lands at its rank, then SORT_LAT-1 more stages.
  logic [WIDTH-1:0] pipe [0:SORT_LAT-1][0:31];

  function automatic int rank_of(int i);
    int r = 0;
    for (int j = 0; j < 32; j++)
      if (sort_in[j] < sort_in[i] || (sort_in[j] == sort_in[i] && j < i)) r++;
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 32; i++) pipe[0][rank_of(i)] <= sort_in[i];
    for (int k = 1; k < SORT_LAT; k++)
      for (int i = 0; i < 32; i++) pipe[k][i] <= pipe[k-1][i];
  end

  always_comb begin
    for (int i = 0; i < 32; i++) sort_out[i] = pipe[SORT_LAT-1][i];
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Offer one element after 'gap' idle cycles and wait for its acceptance.
  task automatic send_elem(input logic [WIDTH-1:0] d, input logic last, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
    end else begin
      sent_q.push_back(d);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int gap, input bit ordered);
    sent_q.delete();
    for (int i = 0; i < 32; i++)
      send_elem(ordered ? WIDTH'(31 - i) : WIDTH'($urandom), 1'b0, gap);
  endtask

  // Collect n outputs. rmode: 0 always ready, 1 alternating, 2 random.
  // junk drives garbage into the input while the controller is busy.
  task automatic recv(input int n, input int rmode, input bit junk);
    int cyc = 0;
    int viol = 0;
    int unstable = 0;
    bit stalled = 1'b0;
    bit hs;
    logic [WIDTH-1:0] held = '0;
    logic held_last = 1'b0;
    got_q.delete();
    last_q.delete();
    while (got_q.size() < n && cyc < 2000) begin
      if (stalled && out_valid && (out_data !== held || out_last !== held_last)) unstable++;
      if (in_ready !== 1'b0 || busy !== 1'b1) viol++;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      hs = out_valid && out_ready;
      in_valid = junk && !(hs && got_q.size() == n - 1);
      in_data  = WIDTH'($urandom);
      if (hs) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
      end
      stalled   = out_valid && !out_ready;
      held      = out_data;
      held_last = out_last;
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got_q.size() != n) begin
      failures++;
      $display("FAIL recv_count got=%0d required=%0d", got_q.size(), n);
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL busy_in_ready violations=%0d required=0", viol);
    end
    checks++;
    if (unstable != 0) begin
      failures++;
      $display("FAIL stall_stability changes=%0d required=0", unstable);
    end
  endtask

  // Compare received stream with the sorted accepted elements; bump frame count.
  task automatic score_frame(input string name, input int n);
    logic [WIDTH-1:0] exp_q[$];
    exp_q = sent_q;
    exp_q.sort();
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size() && i < exp_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL %s data[%0d] got=%h required=%h", name, i, got_q[i], exp_q[i]);
        end
        checks++;
        if (last_q[i] !== (i == n - 1)) begin
          failures++;
          $display("FAIL %s last[%0d] got=%b required=%b", name, i, last_q[i], (i == n - 1));
        end
      end
    end
    exp_frames++;
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL %s frame_cnt got=%0d required=%0d", name, frame_cnt, exp_frames);
    end
  endtask

  // Network input must mirror accepted order; pad slots are all-ones.
  task automatic score_sort_in(input string name, input int n);
    int bad = 0;
    for (int i = 0; i < 32; i++)
      if (sort_in[i] !== ((i < n) ? sent_q[i] : {WIDTH{1'b1}})) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s sort_in bad_slots=%0d required=0", name, bad);
    end
  endtask

  task automatic score_idle(input string name);
    int bad = 0;
    for (int i = 0; i < 32; i++) if (sort_in[i] !== '0) bad++;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s flags in_ready=%b out_valid=%b out_last=%b busy=%b required=1000",
               name, in_ready, out_valid, out_last, busy);
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL %s frame_cnt got=%0d required=0", name, frame_cnt);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s sort_in nonzero_slots=%0d required=0", name, bad);
    end
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_frames = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    score_idle("reset_held");
    rst = 1'b0;
    @(negedge clk);
    score_idle("reset_released");
  endtask

  task automatic test_ordered;
    int k = 0;
    send_frame(0, 1'b1);
    score_sort_in("ordered", 32);
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != SORT_LAT + 2) begin
      failures++;
      $display("FAIL latency got=%0d required=%0d", k, SORT_LAT + 2);
    end
    recv(32, 0, 1'b0);
    score_frame("ordered", 32);
  endtask

  task automatic test_backpressure;
    send_frame(0, 1'b1);
    recv(32, 1, 1'b0);
    score_frame("backpressure", 32);
  endtask

  task automatic test_sparse;
    send_frame(2, 1'b0);
    score_sort_in("sparse", 32);
    recv(32, 2, 1'b0);
    score_frame("sparse", 32);
  endtask

  task automatic test_reset_mid;
    int vhigh = 0;
    send_frame(0, 1'b0);
    repeat (5) @(negedge clk);
    pulse_reset();
    score_idle("reset_in_wait");
    send_frame(0, 1'b0);
    recv(10, 0, 1'b0);
    pulse_reset();
    score_idle("reset_in_drain");
    out_ready = 1'b1;
    repeat (SORT_LAT + 5) begin
      if (out_valid) vhigh++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (vhigh != 0) begin
      failures++;
      $display("FAIL reset_partial_output out_valid_cycles=%0d required=0", vhigh);
    end
    send_frame(0, 1'b0);
    recv(32, 2, 1'b0);
    score_frame("after_reset", 32);
  endtask

  task automatic test_pad;
    logic [WIDTH-1:0] vals [0:4];
    vals[0] = 16'd9; vals[1] = 16'd3; vals[2] = 16'd7; vals[3] = 16'd1; vals[4] = 16'd5;
    sent_q.delete();
    for (int i = 0; i < 5; i++) send_elem(vals[i], (i == 4), 0);
`ifdef SORT_PAD_EN
    score_sort_in("pad", 5);
    recv(5, 1, 1'b0);
    score_frame("pad", 5);
`else
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pad_ignored in_ready=%b busy=%b required=1,0", in_ready, busy);
    end
    for (int i = 5; i < 32; i++) send_elem(WIDTH'($urandom), 1'b0, 0);
    score_sort_in("pad_ignored", 32);
    recv(32, 0, 1'b0);
    score_frame("pad_ignored", 32);
`endif
  endtask

  task automatic test_back_to_back;
    pulse_reset();
    for (int f = 0; f < 3; f++) begin
      send_frame(0, 1'b0);
      recv(32, 0, 1'b1);
      score_frame("back_to_back", 32);
    end
  endtask

  initial begin
    test_reset();
    test_ordered();
    test_backpressure();
    test_sparse();
    test_reset_mid();
    test_pad();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
